conv_seq_ctrl: RTL and testbench

- Sequencer in front of the convolution datapath. It accepts the per-frame sample stream and pushes each sample into the LEN-tap shift window.
- Tracks window fill. Once the window holds a full valid window, it starts one convolution core cycle per push and stalls the stream until the core reports done.
- Marks the last window of each frame and reports per-frame window counts and errors.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_seq_cnt.sv | 62 ++++++
 rtl/conv_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer.
// Optional build macro: CONV_ZERO_FLUSH_EN (consumed by conv_seq_ctrl).
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int LEN    = 3;

    typedef logic [DATA_W-1:0] data_t;

    // Full window contents; kept for the datapath side of the slice.
    typedef data_t [LEN-1:0] data_vector_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_WAIT,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/conv_seq_cnt.sv
// Counters for the sequencer: shift-window fill level, flush zero count and
// the saturating per-frame window counter.
// Optional build macro: CONV_ZERO_FLUSH_EN (no effect in this file).
module conv_seq_cnt
    import conv_pkg::*;
#(
    parameter int LEN   = conv_pkg::LEN,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fill_load,
    input  logic                     fill_inc,
    input  logic                     flush_clr,
    input  logic                     flush_inc,
    input  logic                     win_clr,
    input  logic                     win_inc,
    output logic [$clog2(LEN+1)-1:0] fill_cnt,
    output logic [$clog2(LEN+1)-1:0] flush_cnt,
    output logic [CNT_W-1:0]         win_cnt
);

    localparam int            FW       = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN);

    // Fill level: the first push of a frame loads 1, then counts up and
    // stops at LEN once the window is full.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (fill_load) begin
            fill_cnt <= FW'(1);
        end else if (fill_inc && fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Number of flush zeros pushed in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (flush_clr) begin
            flush_cnt <= '0;
        end else if (flush_inc) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Windows started in this frame, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (win_clr) begin
            win_cnt <= '0;
        end else if (win_inc && win_cnt != '1) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer in front of the convolution datapath: feeds samples into the
// LEN-tap shift window, starts one core cycle per full window and stalls the
// stream until the core reports done.
// Optional build macro: CONV_ZERO_FLUSH_EN -- when defined, the end of a
// frame pushes LEN-1 zeros so a frame of N samples yields N windows.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int LEN   = conv_pkg::LEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  data_t            s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output data_t            sh_data,
    output logic             sh_valid,
    input  logic             sh_ready,
    output logic             core_start,
    output logic             core_last,
    input  logic             core_done,
    output logic             frame_done,
    output logic [CNT_W-1:0] win_cnt,
    output logic             err_short,
    output logic             err_spur
);

    localparam int            FW          = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_LAST   = FW'(LEN - 1);
    localparam logic [FW-1:0] FLUSH_FINAL = FW'(LEN - 2);
`ifdef CONV_ZERO_FLUSH_EN
    localparam bit ZERO_FLUSH = 1'b1;
`else
    localparam bit ZERO_FLUSH = 1'b0;
`endif

    seq_state_t    state, state_next;
    logic [FW-1:0] fill_cnt, flush_cnt;
    logic          accepting, push;
    logic          fill_load, fill_inc, flush_clr, flush_inc, win_clr;
    logic          win_go, win_is_last, short_set, flush_set;
    logic          win_last, flushing;

    conv_seq_cnt #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_load (fill_load),
        .fill_inc  (fill_inc),
        .flush_clr (flush_clr),
        .flush_inc (flush_inc),
        .win_clr   (win_clr),
        .win_inc   (win_go),
        .fill_cnt  (fill_cnt),
        .flush_cnt (flush_cnt),
        .win_cnt   (win_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (push) state_next = !s_last ? ST_FILL :
                                             (ZERO_FLUSH ? ST_FLUSH : ST_DONE);
            ST_FILL:  if (win_go)              state_next = ST_WAIT;
                      else if (push && s_last) state_next = ZERO_FLUSH ? ST_FLUSH : ST_DONE;
            ST_RUN:   if (win_go) state_next = ST_WAIT;
            ST_WAIT:  if (core_done) state_next = win_last ? ST_DONE :
                                                  (flushing ? ST_FLUSH : ST_RUN);
            ST_FLUSH: if (win_go) state_next = ST_WAIT;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake, push data and counter/flag controls for the current state.
    // NOTE: every signal gets a default before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        accepting   = rst_n && (state == ST_IDLE || state == ST_FILL || state == ST_RUN);
        s_ready     = accepting & sh_ready;
        sh_valid    = accepting ? s_valid : (state == ST_FLUSH);
        sh_data     = accepting ? s_data : '0;
        push        = sh_valid & sh_ready;
        frame_done  = (state == ST_DONE);
        fill_load   = 1'b0;
        fill_inc    = 1'b0;
        flush_clr   = 1'b0;
        flush_inc   = 1'b0;
        win_clr     = 1'b0;
        win_go      = 1'b0;
        win_is_last = 1'b0;
        short_set   = 1'b0;
        flush_set   = 1'b0;
        case (state)
            ST_IDLE: if (push) begin
                fill_load = 1'b1;
                flush_clr = 1'b1;
                win_clr   = 1'b1;
                short_set = s_last & ~ZERO_FLUSH;
                flush_set = s_last & ZERO_FLUSH;
            end
            ST_FILL: if (push) begin
                fill_inc = 1'b1;
                if (fill_cnt == FILL_LAST) begin
                    win_go      = 1'b1;
                    win_is_last = s_last & ~ZERO_FLUSH;
                    flush_set   = s_last & ZERO_FLUSH;
                end else if (s_last) begin
                    short_set = ~ZERO_FLUSH;
                    win_clr   = ~ZERO_FLUSH;
                    flush_set = ZERO_FLUSH;
                end
            end
            ST_RUN: if (push) begin
                win_go      = 1'b1;
                win_is_last = s_last & ~ZERO_FLUSH;
                flush_set   = s_last & ZERO_FLUSH;
            end
            ST_FLUSH: if (push) begin
                fill_inc  = 1'b1;
                flush_inc = 1'b1;
                if (fill_cnt >= FILL_LAST) begin
                    win_go      = 1'b1;
                    win_is_last = (flush_cnt == FLUSH_FINAL);
                end
            end
            default: ;
        endcase
    end

    // Registered core handshake, frame flags and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start <= 1'b0;
            core_last  <= 1'b0;
            win_last   <= 1'b0;
            flushing   <= 1'b0;
            err_short  <= 1'b0;
            err_spur   <= 1'b0;
        end else begin
            core_start <= win_go;
            core_last  <= win_go & win_is_last;
            if (win_go)                         win_last  <= win_is_last;
            if (flush_set)                      flushing  <= 1'b1;
            else if (state == ST_DONE)          flushing  <= 1'b0;
            if (short_set)                      err_short <= 1'b1;
            if (core_done && state != ST_WAIT)  err_spur  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed testbench for conv_seq_ctrl (LEN from conv_pkg, expected 3).
// Optional build macro: CONV_ZERO_FLUSH_EN selects the zero-flush frame test.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    localparam int CNT_W = 16;
`ifdef CONV_ZERO_FLUSH_EN
    localparam int EXP_RST_WIN = 3;
`else
    localparam int EXP_RST_WIN = 1;
`endif

    logic             clk, rst_n;
    data_t            s_data, sh_data;
    logic             s_valid, s_last, s_ready, sh_valid, sh_ready;
    logic             core_start, core_last, core_done, frame_done;
    logic [CNT_W-1:0] win_cnt;
    logic             err_short, err_spur;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc, n_push, n_zero, n_start, n_last, n_fd, last_idx, done_cd;
    int    push_cyc[$];
    data_t start_data[$];
    logic  accepted;

    conv_seq_ctrl #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .sh_data    (sh_data),
        .sh_valid   (sh_valid),
        .sh_ready   (sh_ready),
        .core_start (core_start),
        .core_last  (core_last),
        .core_done  (core_done),
        .frame_done (frame_done),
        .win_cnt    (win_cnt),
        .err_short  (err_short),
        .err_spur   (err_spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_push = 0; n_zero = 0; n_start = 0; n_last = 0; n_fd = 0; last_idx = 0;
        push_cyc.delete();
        start_data.delete();
    endtask

    // One clock: sample the push before the edge, then model the core
    // (core_done two cycles after each core_start) and log outputs after it.
    task automatic tick();
        logic  pushed;
        data_t pdata;
        @(negedge clk);
        pushed   = sh_valid && sh_ready;
        pdata    = sh_data;
        accepted = s_valid && s_ready;
        if (pushed) begin
            n_push++;
            push_cyc.push_back(cyc);
            if (!s_valid) n_zero++;
        end
        @(posedge clk);
        #1;
        cyc++;
        core_done = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) core_done = 1'b1;
        end
        if (core_start) begin
            n_start++;
            start_data.push_back(pushed ? pdata : 8'hEE);
            if (core_last) begin
                n_last++;
                last_idx = n_start;
            end
            done_cd = 2;
        end
        if (frame_done) n_fd++;
    endtask

    task automatic send(input data_t d, input logic last);
        s_data = d; s_valid = 1'b1; s_last = last; accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) tick();
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        check($sformatf("accept_%0d", d), 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && n_fd == 0; i++) tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        sh_ready = 1'b0; core_done = 1'b0; cyc = 0; done_cd = 0; accepted = 1'b0;
        clear_stats();
        #12;
        check("rst_core_start", 32'(core_start), 0);
        check("rst_core_last",  32'(core_last),  0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_win_cnt",    32'(win_cnt),    0);
        check("rst_err_short",  32'(err_short),  0);
        check("rst_err_spur",   32'(err_spur),   0);
        check("rst_s_ready",    32'(s_ready),    0);
        check("rst_sh_valid",   32'(sh_valid),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sh_ready = 1'b1;

`ifdef CONV_ZERO_FLUSH_EN
        // Frame 1,2,3(last) with zero flush: 3 windows, last on the third.
        clear_stats();
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
        drain();
        check("zf_zero_pushes", 32'(n_zero),        2);
        check("zf_starts",      32'(n_start),       3);
        check("zf_n_last",      32'(n_last),        1);
        check("zf_last_idx",    32'(last_idx),      3);
        check("zf_start0_data", 32'(start_data[0]), 3);
        check("zf_start1_data", 32'(start_data[1]), 0);
        check("zf_start2_data", 32'(start_data[2]), 0);
        check("zf_win_cnt",     32'(win_cnt),       3);
        check("zf_frame_done",  32'(n_fd),          1);
        check("zf_err_short",   32'(err_short),     0);
`else
        // Frame 5,6,7,8(last): windows start after pushes of 7 and 8.
        clear_stats();
        send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b0); send(8'd8, 1'b1);
        drain();
        check("a_pushes",      32'(n_push),                    4);
        check("a_starts",      32'(n_start),                   2);
        check("a_start0_data", 32'(start_data[0]),             7);
        check("a_start1_data", 32'(start_data[1]),             8);
        check("a_n_last",      32'(n_last),                    1);
        check("a_last_idx",    32'(last_idx),                  2);
        check("a_push_gap",    32'(push_cyc[3] - push_cyc[2]), 4);
        check("a_frame_done",  32'(n_fd),                      1);
        check("a_win_cnt",     32'(win_cnt),                   2);
        check("a_err_short",   32'(err_short),                 0);

        // Short frame 1,2(last): no window, err_short, win_cnt cleared.
        clear_stats();
        send(8'd1, 1'b0); send(8'd2, 1'b1);
        drain();
        check("b_starts",     32'(n_start),   0);
        check("b_frame_done", 32'(n_fd),      1);
        check("b_err_short",  32'(err_short), 1);
        check("b_win_cnt",    32'(win_cnt),   0);

        // Four-cycle sh_ready stall mid-frame.
        clear_stats();
        send(8'd10, 1'b0); send(8'd11, 1'b0);
        sh_ready = 1'b0; s_data = 8'd12; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stall_s_ready_%0d", i), 32'(s_ready), 0);
        end
        check("stall_pushes", 32'(n_push),  2);
        check("stall_starts", 32'(n_start), 0);
        sh_ready = 1'b1;
        send(8'd12, 1'b0); send(8'd13, 1'b1);
        drain();
        check("stall_starts_after", 32'(n_start),       2);
        check("stall_start0_data",  32'(start_data[0]), 12);
        check("stall_start1_data",  32'(start_data[1]), 13);
        check("stall_last_idx",     32'(last_idx),      2);
        check("stall_win_cnt",      32'(win_cnt),       2);
        check("stall_frame_done",   32'(n_fd),          1);
`endif

        // Spurious core_done while idle.
        clear_stats();
        check("spur_before", 32'(err_spur), 0);
        core_done = 1'b1;
        tick();
        tick();
        check("spur_err",        32'(err_spur),   1);
        check("spur_s_ready",    32'(s_ready),    1);
        check("spur_starts",     32'(n_start),    0);
        check("spur_frame_done", 32'(n_fd),       0);

        // Reset while waiting on the core, then a clean 3-sample frame.
        clear_stats();
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
        check("wait_core_start", 32'(core_start), 1);
        #2;
        rst_n = 1'b0; done_cd = 0; core_done = 1'b0;
        #1;
        check("wrst_core_start", 32'(core_start), 0);
        check("wrst_core_last",  32'(core_last),  0);
        check("wrst_win_cnt",    32'(win_cnt),    0);
        check("wrst_err_short",  32'(err_short),  0);
        check("wrst_err_spur",   32'(err_spur),   0);
        check("wrst_frame_done", 32'(frame_done), 0);
        check("wrst_s_ready",    32'(s_ready),    0);
        check("wrst_sh_valid",   32'(sh_valid),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        send(8'd4, 1'b0); send(8'd5, 1'b0); send(8'd6, 1'b1);
        drain();
        check("post_rst_win_cnt",    32'(win_cnt),   EXP_RST_WIN);
        check("post_rst_starts",     32'(n_start),   EXP_RST_WIN);
        check("post_rst_n_last",     32'(n_last),    1);
        check("post_rst_frame_done", 32'(n_fd),      1);
        check("post_rst_err_short",  32'(err_short), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
